// File: rtl/des_key_schedule_seq_if.sv
// des_key_schedule_seq_if
// Groups the key-load handshake and the round-key output stream of the DES
// key-schedule engine.
//   key_in/mode/start_valid/start_ready : key load request (master -> slave)
//   round_key/round_idx/key_valid/key_last/key_ready : round-key stream
//   busy : engine is in LOAD or GEN
// master = key source / round-key consumer, slave = schedule engine.
interface des_key_schedule_seq_if #(
   parameter int IDX_W = 4
);
   logic [63:0]      key_in;
   logic             mode;
   logic             start_valid;
   logic             start_ready;
   logic [47:0]      round_key;
   logic [IDX_W-1:0] round_idx;
   logic             key_valid;
   logic             key_ready;
   logic             key_last;
   logic             busy;

   modport master (
      output key_in, mode, start_valid, key_ready,
      input  start_ready, round_key, round_idx, key_valid, key_last, busy
   );

   modport slave (
      input  key_in, mode, start_valid, key_ready,
      output start_ready, round_key, round_idx, key_valid, key_last, busy
   );
endinterface

// File: rtl/des_key_schedule_seq.sv
// des_key_schedule_seq
// Sequential DES key schedule: loads a 64-bit key, applies PC-1 and then
// emits one registered 48-bit PC-2 round key per accepted beat, K1..K16 for
// encrypt and K16..K1 for decrypt. Decrypt keys are derived on the fly by
// right-rotating the C/D halves, so no key storage is needed.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : des_key_schedule_seq_if.slave (load handshake + key stream)
module des_key_schedule_seq #(
   parameter int                    NUM_ROUNDS = 16,
   parameter logic [NUM_ROUNDS-1:0] SHIFT_MASK = 16'h8103,
   parameter int                    IDX_W      = $clog2(NUM_ROUNDS)
) (
   input logic                  clk,
   input logic                  reset,
   des_key_schedule_seq_if.slave bus
);

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Total rotation over a full schedule; decrypt starts from C16/D16,
   // which is C0/D0 rotated by this amount (zero for standard DES).
   function automatic int total_shift();
      int t;
      t = 0;
      for (int i = 0; i < NUM_ROUNDS; i++) t += SHIFT_MASK[i] ? 1 : 2;
      return t;
   endfunction

   localparam logic [4:0] TOTAL_MOD = 5'(total_shift() % 28);

   // DES bit 1 is the MSB of every vector.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
      return r;
   endfunction

   // n in 0..27; n = 0 leaves x unchanged because x >> 28 is zero.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
      return (x << n) | (x >> (5'd28 - n));
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
      return rotl28(x, (n == 5'd0) ? 5'd0 : 5'd28 - n);
   endfunction

   // Loop compare instead of direct indexing keeps out-of-range round
   // numbers (evaluated but unused on the last beat) well defined.
   function automatic logic [4:0] shift_amt(input int i);
      logic [4:0] a;
      a = 5'd2;
      for (int k = 0; k < NUM_ROUNDS; k++)
         if (k == i && SHIFT_MASK[k]) a = 5'd1;
      return a;
   endfunction

   typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

   state_t           state, state_nxt;
   logic [27:0]      c, d, c_nxt, d_nxt;
   logic [47:0]      round_key;
   logic [IDX_W-1:0] round_idx;
   logic             key_valid;
   logic             mode_r;
   logic             xfer, last;
   int               idx_n;

   assign xfer  = key_valid && bus.key_ready;
   assign last  = key_valid && (round_idx == IDX_W'(NUM_ROUNDS - 1));
   assign idx_n = int'(round_idx) + 1;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_valid) state_nxt = LOAD;
         LOAD:    state_nxt = GEN;
         GEN:     if (xfer && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      bus.start_ready = (state == IDLE);
      bus.busy        = (state == LOAD) || (state == GEN);
      bus.round_key   = round_key;
      bus.round_idx   = round_idx;
      bus.key_valid   = key_valid;
      bus.key_last    = last;
   end

   // C/D for the key about to be produced: first key in LOAD, next beat in GEN
   always_comb begin
      c_nxt = c;
      d_nxt = d;
      if (state == LOAD) begin
         if (mode_r) begin
            c_nxt = rotl28(c, TOTAL_MOD);
            d_nxt = rotl28(d, TOTAL_MOD);
         end else begin
            c_nxt = rotl28(c, shift_amt(0));
            d_nxt = rotl28(d, shift_amt(0));
         end
      end else if (state == GEN) begin
         if (mode_r) begin
            // undo the shift of round NUM_ROUNDS-idx_n+1 to step backwards
            c_nxt = rotr28(c, shift_amt(NUM_ROUNDS - idx_n));
            d_nxt = rotr28(d, shift_amt(NUM_ROUNDS - idx_n));
         end else begin
            c_nxt = rotl28(c, shift_amt(idx_n));
            d_nxt = rotl28(d, shift_amt(idx_n));
         end
      end
   end

   // datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         c         <= '0;
         d         <= '0;
         round_key <= '0;
         round_idx <= '0;
         key_valid <= 1'b0;
         mode_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start_valid) begin
               {c, d}    <= pc1(bus.key_in);
               mode_r    <= bus.mode;
               round_idx <= '0;
            end
            LOAD: begin
               c         <= c_nxt;
               d         <= d_nxt;
               round_key <= pc2({c_nxt, d_nxt});
               round_idx <= '0;
               key_valid <= 1'b1;
            end
            GEN: if (xfer) begin
               if (last) begin
                  key_valid <= 1'b0;
               end else begin
                  c         <= c_nxt;
                  d         <= d_nxt;
                  round_key <= pc2({c_nxt, d_nxt});
                  round_idx <= round_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
